// File: rtl/sum_accumulator_if.sv
// Handshake bundle for sum_accumulator: sample input side and result output side.
// The slave modport is the accumulator's view; master is the environment's view.
interface sum_accumulator_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_sum;
  logic        in_cout;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_total;
  logic [7:0]  out_count;
  logic        out_overflow;

  modport slave (
    input  in_valid,
    input  in_sum,
    input  in_cout,
    input  flush,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_total,
    output out_count,
    output out_overflow
  );

  modport master (
    output in_valid,
    output in_sum,
    output in_cout,
    output flush,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_total,
    input  out_count,
    input  out_overflow
  );
endinterface

// File: rtl/sum_accumulator.sv
// Accumulates 9-bit adder results ({cout,sum}) into a 16-bit total over blocks of N_SAMPLES.
// Define SUM_ACCUMULATOR_SATURATE_EN to clamp the total at 0xFFFF instead of wrapping.
module sum_accumulator #(
  parameter int unsigned N_SAMPLES = 4
) (
  input logic         clk,
  input logic         rst_n,
  sum_accumulator_if.slave bus
);

  if (N_SAMPLES < 1 || N_SAMPLES > 255) begin : gen_bad_param
    $error("sum_accumulator: N_SAMPLES must be in 1..255");
  end

  localparam logic [7:0] NLast = 8'(N_SAMPLES);

  typedef enum logic {StAccum, StEmit} state_e;

  state_e      state_q, state_d;
  logic [15:0] acc_q, acc_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        ovf_q, ovf_d;

  logic [8:0]  sample;
  logic [16:0] sum_wide;
  logic [15:0] acc_add;

  assign sample   = {bus.in_cout, bus.in_sum};
  assign sum_wide = {1'b0, acc_q} + {8'd0, sample};

`ifdef SUM_ACCUMULATOR_SATURATE_EN
  assign acc_add = sum_wide[16] ? 16'hFFFF : sum_wide[15:0];
`else
  assign acc_add = sum_wide[15:0];
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StAccum: begin
        if (bus.in_valid) begin
          acc_d = acc_add;
          cnt_d = cnt_q + 8'd1;
          ovf_d = ovf_q | sum_wide[16];
        end
        // cnt_d already includes a sample accepted on this edge, so flush+valid closes with it.
        if ((bus.in_valid && (cnt_d == NLast)) || (bus.flush && (cnt_d != 8'd0))) begin
          state_d = StEmit;
        end
      end
      StEmit: begin
        if (bus.out_ready) begin
          state_d = StAccum;
          acc_d   = 16'd0;
          cnt_d   = 8'd0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = StAccum;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StAccum;
      acc_q   <= 16'd0;
      cnt_q   <= 8'd0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready     = (state_q == StAccum);
  assign bus.out_valid    = (state_q == StEmit);
  assign bus.out_total    = acc_q;
  assign bus.out_count    = cnt_q;
  assign bus.out_overflow = ovf_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed self-checking bench for sum_accumulator: N_SAMPLES=4 and N_SAMPLES=200 instances.
module tb_sum_accumulator;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  sum_accumulator_if a_if ();
  sum_accumulator_if b_if ();

  sum_accumulator #(.N_SAMPLES(4)) dut_a (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (a_if.slave)
  );

  sum_accumulator #(.N_SAMPLES(200)) dut_b (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [7:0] s, input logic c);
    a_if.in_valid = 1'b1;
    a_if.in_sum   = s;
    a_if.in_cout  = c;
    step();
    a_if.in_valid = 1'b0;
  endtask

  task automatic ack_a();
    a_if.out_ready = 1'b1;
    step();
    a_if.out_ready = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    a_if.in_valid = 0; a_if.in_sum = 0; a_if.in_cout = 0; a_if.flush = 0; a_if.out_ready = 0;
    b_if.in_valid = 0; b_if.in_sum = 0; b_if.in_cout = 0; b_if.flush = 0; b_if.out_ready = 0;
    rst_n = 1'b0;
    #12;
    chk("reset_valid", a_if.out_valid, 0);
    chk("reset_ready", a_if.in_ready, 1);
    chk("reset_total", a_if.out_total, 0);
    chk("reset_count", a_if.out_count, 0);
    chk("reset_ovf", a_if.out_overflow, 0);
    rst_n = 1'b1;
    step();

    // Full block of 4 with carry-in bits
    send_a(8'h0F, 1'b0);
    send_a(8'h00, 1'b1);
    send_a(8'h00, 1'b1);
    chk("blk4_not_yet", a_if.out_valid, 0);
    send_a(8'h00, 1'b1);
    chk("blk4_valid", a_if.out_valid, 1);
    chk("blk4_in_ready", a_if.in_ready, 0);
    chk("blk4_total", a_if.out_total, 16'h030F);
    chk("blk4_count", a_if.out_count, 4);
    chk("blk4_ovf", a_if.out_overflow, 0);
    ack_a();
    chk("blk4_ack_valid", a_if.out_valid, 0);
    chk("blk4_ack_total", a_if.out_total, 0);
    chk("blk4_ack_count", a_if.out_count, 0);

    // Flush with empty block is ignored
    a_if.flush = 1'b1;
    step();
    a_if.flush = 1'b0;
    chk("flush_empty", a_if.out_valid, 0);
    step();
    chk("flush_empty2", a_if.out_valid, 0);

    // Flush alone after two samples
    send_a(8'd10, 1'b0);
    send_a(8'd20, 1'b0);
    chk("flush_pre", a_if.out_valid, 0);
    a_if.flush = 1'b1;
    step();
    a_if.flush = 1'b0;
    chk("flush_valid", a_if.out_valid, 1);
    chk("flush_total", a_if.out_total, 16'h001E);
    chk("flush_count", a_if.out_count, 2);
    ack_a();
    chk("flush_ack", a_if.out_valid, 0);

    // Flush coinciding with a sample includes it
    send_a(8'd5, 1'b0);
    a_if.flush = 1'b1;
    send_a(8'd7, 1'b0);
    a_if.flush = 1'b0;
    chk("flushv_valid", a_if.out_valid, 1);
    chk("flushv_total", a_if.out_total, 16'h000C);
    chk("flushv_count", a_if.out_count, 2);

    // Backpressure in EMIT: inputs ignored, outputs held
    a_if.in_valid = 1'b1;
    a_if.in_sum   = 8'd9;
    a_if.flush    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_valid", a_if.out_valid, 1);
      chk("hold_in_ready", a_if.in_ready, 0);
      chk("hold_total", a_if.out_total, 16'h000C);
      chk("hold_count", a_if.out_count, 2);
    end
    a_if.flush = 1'b0;
    a_if.out_ready = 1'b1;
    step();
    a_if.out_ready = 1'b0;
    a_if.in_valid  = 1'b0;
    chk("hold_ack_valid", a_if.out_valid, 0);
    chk("hold_ack_total", a_if.out_total, 0);
    chk("hold_ack_count", a_if.out_count, 0);
    send_a(8'd3, 1'b0);
    chk("new_blk_total", a_if.out_total, 3);
    chk("new_blk_count", a_if.out_count, 1);

    // 200 samples of 0x1FF: 102200 wraps to 0x8F38 or clamps at 0xFFFF
    b_if.in_valid = 1'b1;
    b_if.in_sum   = 8'hFF;
    b_if.in_cout  = 1'b1;
    for (int i = 0; i < 199; i++) step();
    chk("b199_valid", b_if.out_valid, 0);
    chk("b199_count", b_if.out_count, 199);
    step();
    b_if.in_valid = 1'b0;
    chk("b200_valid", b_if.out_valid, 1);
    chk("b200_count", b_if.out_count, 200);
    chk("b200_ovf", b_if.out_overflow, 1);
`ifdef SUM_ACCUMULATOR_SATURATE_EN
    chk("b200_total", b_if.out_total, 16'hFFFF);
`else
    chk("b200_total", b_if.out_total, 16'h8F38);
`endif

    // Asynchronous reset mid-block (dut_a has 1 sample; add 2 more) and with dut_b in EMIT
    send_a(8'd4, 1'b0);
    send_a(8'd6, 1'b0);
    chk("pre_rst_count", a_if.out_count, 3);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_a_total", a_if.out_total, 0);
    chk("rst_a_count", a_if.out_count, 0);
    chk("rst_a_valid", a_if.out_valid, 0);
    chk("rst_b_valid", b_if.out_valid, 0);
    chk("rst_b_ovf", b_if.out_overflow, 0);
    chk("rst_b_total", b_if.out_total, 0);
    #2;
    rst_n = 1'b1;
    step();
    send_a(8'd1, 1'b0);
    send_a(8'd1, 1'b0);
    send_a(8'd1, 1'b0);
    send_a(8'd1, 1'b0);
    chk("post_rst_valid", a_if.out_valid, 1);
    chk("post_rst_total", a_if.out_total, 16'h0004);
    chk("post_rst_count", a_if.out_count, 4);
    ack_a();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sum_accumulator.md
SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 The block SHALL have parameter N_SAMPLES, default 4: accepted samples per block, legal range 1..255.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port in_valid  input  1  upstream adder result valid.
REQ-005 The block SHALL have port in_ready  output  1  block can accept a sample.
REQ-006 The block SHALL have port in_sum  input  8  adder sum bits (c).
REQ-007 The block SHALL have port in_cout  input  1  adder carry-out.
REQ-008 The block SHALL have port flush  input  1  close the current block early.
REQ-009 The block SHALL have port out_valid  output  1  result available.
REQ-010 The block SHALL have port out_ready  input  1  downstream accepts result.
REQ-011 The block SHALL have port out_total  output  16  accumulated total.
REQ-012 The block SHALL have port out_count  output  8  samples in this total.
REQ-013 The block SHALL have port out_overflow  output  1  total exceeded 16 bits during this block.

Function
REQ-014 The block SHALL have exactly two states: ACCUM (in_ready=1, out_valid=0) and EMIT (in_ready=0, out_valid=1).
REQ-015 The block SHALL accept a sample in ACCUM when in_valid=1; value = {in_cout,in_sum}, zero-extended 9 bits (0..511), added to the 16-bit accumulator; count increments by 1.
REQ-016 The block SHALL move ACCUM->EMIT on the edge at which the count reaches N_SAMPLES; out_valid SHALL be high the next cycle (1-cycle latency).
REQ-017 The block SHALL move ACCUM->EMIT when flush=1 and count (including any sample accepted the same edge) is >=1; flush with count 0 SHALL be ignored.
REQ-018 The block SHALL, when flush and in_valid coincide, include that sample in the emitted total.
REQ-019 The block SHALL, in EMIT, hold out_total, out_count and out_overflow stable until out_valid & out_ready.
REQ-020 The block SHALL, on the EMIT handshake edge, clear the accumulator, count and overflow flag and return to ACCUM; no sample is accepted that edge.
REQ-021 The block SHALL ignore in_valid and flush while in EMIT.
REQ-022 The block SHALL set out_overflow (sticky for the block) on any addition whose true result exceeds 0xFFFF.
REQ-023 The block SHALL drive out_total/out_count from internal registers in both states; their values are only meaningful while out_valid=1.

Reset
REQ-024 The block SHALL, while rst_n=0, asynchronously force state ACCUM, accumulator 0, count 0, out_overflow 0, out_valid 0 and out_total 0x0000.
REQ-025 The block SHALL discard any partial block on reset mid-operation; after rst_n rises, the first accepted sample starts a new block.

Configuration
REQ-026 The block SHALL, with macro SUM_ACCUMULATOR_SATURATE_EN defined, clamp the accumulator at 0xFFFF on overflow; without it, the accumulator SHALL wrap modulo 2^16; out_overflow behaves identically in both builds.

Verification
REQ-027 The bench SHALL apply N_SAMPLES=4 and samples (0x0F,0),(0x00,1),(0x00,1),(0x00,1) -> out_total 0x030F, out_count 4, out_overflow 0, out_valid one cycle after the 4th accept.
REQ-028 The bench SHALL apply N_SAMPLES=200 and 200 samples (0xFF,1) -> without the macro out_total 0x8F38 and out_overflow 1; with the macro out_total 0xFFFF and out_overflow 1.
REQ-029 The bench SHALL apply N_SAMPLES=4, samples (10,0),(20,0), then flush alone -> out_total 0x001E, out_count 2; a flush with count 0 -> out_valid stays 0.
REQ-030 The bench SHALL apply N_SAMPLES=4, sample (5,0), then flush together with in_valid on sample (7,0) -> out_total 0x000C, out_count 2.
REQ-031 The bench SHALL, in EMIT, hold out_ready=0 for 5 cycles while in_valid=1 -> outputs stable, in_ready 0, no samples taken; then out_ready=1 -> next block starts from 0.
REQ-032 The bench SHALL pulse rst_n low after 3 accepted samples -> all outputs 0 immediately; the next 4 samples of (1,0) -> out_total 0x0004.
